// File: rtl/imem_if.sv
// Fetch interface between the fetch stage (master) and the instruction memory (slave).
//   req_valid/req_ready/req_addr      : request channel, one fetch byte address per handshake
//   resp_valid/resp_ready/resp_data/resp_err : response channel, fetched word and access fault
interface imem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: slave end of the fetch interface.
// Accepts one fetch at a time, reads a word from an internal word-addressed array and
// returns it LATENCY cycles after the accept edge, holding it until resp_ready.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : imem_if slave modport (request and response channels)
//   flush      : drop any in-flight or pending fetch, block new accepts this cycle
//   load_en    : preload write strobe; writes load_data to word load_addr
//   load_addr  : preload word index
//   load_data  : preload word
module imem_responder #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DEPTH_LOG2 = 12,
  parameter int unsigned          LATENCY    = 2,  // legal range 1..15
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_if.slave                 bus,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // Array size in bytes, held wide enough that any ADDR_WIDTH offset compares cleanly.
  localparam logic [63:0] ByteLimit = 64'(4) << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  logic [ADDR_WIDTH-1:0] offset;
  logic                  req_err;
  logic                  accept;

  // Wrapped subtraction: addresses below BASE_ADDR land far above the limit.
  assign offset  = bus.req_addr - BASE_ADDR;
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (64'(offset) >= ByteLimit);

  assign bus.req_ready  = (state_q == StIdle) && !flush && !rst;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // The array is read before this edge's preload write lands, so a
            // same-word load on the accept edge yields the old word.
            data_d = req_err ? '0 : mem_q[offset[DEPTH_LOG2+1:2]];
            err_d  = req_err;
            if (LATENCY == 1) begin
              state_d = StResp;
            end else begin
              state_d = StWait;
              cnt_d   = 4'(LATENCY - 2);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_d = StResp;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Preload port is independent of reset and of the fetch FSM.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        flush;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  imem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  imem_responder #(.LATENCY(2)) u_dut0 (
    .clk       (clk),
    .rst       (rst0),
    .bus       (bus0),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  imem_responder #(.LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .bus       (bus1),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          hold;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en   = 1'b0;
  endtask

  // One fetch on the LATENCY=2 instance; hold>0 keeps resp_ready low for hold cycles.
  task automatic fetch0(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e,
                        input int hold, input string nm);
    int n;
    bus0.resp_ready = (hold == 0);
    bus0.req_addr   = addr;
    bus0.req_valid  = 1'b1;
    chk({nm, " req_ready"}, 64'(bus0.req_ready), 64'd1);
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    n = 1;
    while (!bus0.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd2);
    chk({nm, " data"}, 64'(bus0.resp_data), 64'(exp_d));
    chk({nm, " err"}, 64'(bus0.resp_err), 64'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold {valid,data,err,req_ready}"},
          64'({bus0.resp_valid, bus0.resp_data, bus0.resp_err, bus0.req_ready}),
          64'({1'b1, exp_d, exp_e, 1'b0}));
    end
    bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " idle after handshake {valid,req_ready}"},
        64'({bus0.resp_valid, bus0.req_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic seen;
    rst0 = 1'b1; rst1 = 1'b1; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.resp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.resp_ready = 1'b1;

    vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0, 0, "word0"};
    vecs[1] = '{32'h8000_0008, 32'h00a0_0093, 1'b0, 5, "backpressure"};
    vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b1, 0, "misaligned2"};
    vecs[3] = '{32'h8000_3FFC, 32'hCAFE_F00D, 1'b0, 0, "last_word"};
    vecs[4] = '{32'h8000_4000, 32'h0000_0000, 1'b1, 0, "beyond_array"};
    vecs[5] = '{32'h8000_0004, 32'h1111_1111, 1'b0, 0, "word1"};
    vecs[6] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 2, "below_base"};
    vecs[7] = '{32'h8000_0001, 32'h0000_0000, 1'b1, 0, "misaligned1"};

    repeat (2) @(posedge clk);
    #1;
    chk("req_ready in reset", 64'({bus0.req_ready, bus1.req_ready}), 64'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("reset state {valid,data,err,req_ready}",
        64'({bus0.resp_valid, bus0.resp_data, bus0.resp_err, bus0.req_ready}),
        64'({1'b0, 32'h0, 1'b0, 1'b1}));

    load(12'd0,    32'h0000_0413);
    load(12'd1,    32'h1111_1111);
    load(12'd2,    32'h00a0_0093);
    load(12'd4095, 32'hCAFE_F00D);

    foreach (vecs[i]) fetch0(vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].hold, vecs[i].name);

    // Flush one cycle after accept; the flush-cycle request must be ignored.
    bus0.resp_ready = 1'b1;
    bus0.req_addr = 32'h8000_0000; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_addr = 32'h8000_0008; flush = 1'b1;
    chk("flush req_ready", 64'(bus0.req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus0.req_valid = 1'b0;
    seen = bus0.resp_valid;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen |= bus0.resp_valid;
    end
    chk("flush no response", 64'(seen), 64'd0);
    fetch0(32'h8000_0008, 32'h00a0_0093, 1'b0, 0, "post_flush");

    // Same-edge preload of the fetched word: old word returned, new one next time.
    load_en = 1'b1; load_addr = 12'd1; load_data = 32'hDEAD_BEEF;
    fetch0(32'h8000_0004, 32'h1111_1111, 1'b0, 0, "rdw_old");
    load_en = 1'b0;
    fetch0(32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 0, "rdw_new");

    // Reset while in WAIT drops the fetch.
    bus0.req_addr = 32'h8000_0000; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0; rst0 = 1'b1;
    @(posedge clk); #1;
    chk("rst in wait {valid,req_ready}", 64'({bus0.resp_valid, bus0.req_ready}), 64'd0);
    rst0 = 1'b0;
    #1;
    chk("rst in wait req_ready after", 64'(bus0.req_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      seen |= bus0.resp_valid;
    end
    chk("rst in wait no response", 64'(seen), 64'd0);

    // LATENCY=1 instance: response one cycle after accept, then reset while in RESP.
    bus1.resp_ready = 1'b0;
    bus1.req_addr = 32'h8000_0000; bus1.req_valid = 1'b1;
    chk("lat1 req_ready", 64'(bus1.req_ready), 64'd1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("lat1 {valid,data,err}", 64'({bus1.resp_valid, bus1.resp_data, bus1.resp_err}),
        64'({1'b1, 32'h0000_0413, 1'b0}));
    @(posedge clk); #1;
    chk("lat1 held valid", 64'(bus1.resp_valid), 64'd1);
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("lat1 rst {valid,req_ready,data}",
        64'({bus1.resp_valid, bus1.req_ready, bus1.resp_data}), 64'd0);
    rst1 = 1'b0;
    #1;
    chk("lat1 req_ready after rst", 64'(bus1.req_ready), 64'd1);
    bus1.resp_ready = 1'b1;
    bus1.req_addr = 32'h8000_0006; bus1.req_valid = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("lat1 fault {valid,data,err}", 64'({bus1.resp_valid, bus1.resp_data, bus1.resp_err}),
        64'({1'b1, 32'h0, 1'b1}));
    @(posedge clk); #1;
    chk("lat1 idle {valid,req_ready}", 64'({bus1.resp_valid, bus1.req_ready}), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the slave end of the fetch interface driven by the fetch stage.
- Accepts one fetch request at a time over a valid/ready request channel.
- Reads a word from an internal word-addressed array and returns it on a valid/ready response channel after a programmable latency.
- Supports pipeline flush (drops an in-flight fetch) and a preload write port for test images.

Parameters:
DATA_WIDTH, 32, instruction/data word width
ADDR_WIDTH, 32, request byte-address width
DEPTH_LOG2, 12, log2 of array depth in words (4096 words)
LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15
BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_WIDTH  fetch byte address
resp_valid  out  1  response valid
resp_ready  in  1  fetch stage accepts response
resp_data  out  DATA_WIDTH  fetched instruction; 0 on error
resp_err  out  1  access fault: misaligned or out of range
flush  in  1  discard any in-flight or pending fetch
load_en  in  1  preload write strobe
load_addr  in  DEPTH_LOG2  preload word index
load_data  in  DATA_WIDTH  preload word

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: state=IDLE, resp_valid=0, resp_data=0, resp_err=0, counter=0. req_ready is combinational and reads 0 while rst is high.
- The memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) && !flush && !rst.
- Accept: when req_valid && req_ready at a posedge:
  - Compute offset = req_addr - BASE_ADDR (ADDR_WIDTH-bit unsigned, wrap allowed).
  - err = (req_addr[1:0]!=0) || (offset >= 4*2^DEPTH_LOG2), using the unsigned compare on the wrapped offset.
  - Latch data = err ? 0 : mem[offset[DEPTH_LOG2+1:2]].
  - Latch err.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with counter = LATENCY-2.
- WAIT: if counter==0, go to RESP; otherwise decrement the counter.
- Total latency is exactly LATENCY cycles from the accept edge to the first cycle resp_valid=1.
- RESP: resp_valid=1, with resp_data and resp_err driven from the latched values.
  - While resp_ready=0, resp_valid, resp_data and resp_err stay stable.
  - When resp_valid && resp_ready at a posedge, go to IDLE.
  - A new request cannot be accepted in the same cycle as the handshake, so the minimum spacing between accepts is LATENCY+1 cycles.
- resp_valid=1 only in RESP. In other states, resp_data and resp_err hold their last values.
- Flush (highest priority after rst):
  - flush=1 at a posedge in any state forces IDLE and resp_valid=0. No response is produced for the dropped fetch.
  - A req_valid presented during a flush cycle is not accepted.
  - If a response handshake coincides with flush, the handshake counts as done; the state still goes to IDLE.
- Preload: load_en=1 writes mem[load_addr]=load_data at the posedge, in any state, including during flush.
  - The load port is independent of the fetch channels.
  - Read-during-write to the same word on the accept edge returns the OLD word.
  - A fetch already accepted keeps its latched data even if that word is later overwritten.
- Reset mid-operation drops any in-flight fetch; no response is emitted.
- No outstanding-request queue: exactly 0 or 1 fetch is in flight.

Test Plan:
1. LATENCY=2. Preload mem[0]=32'h00000413. Request 0x8000_0000 accepted at cycle 0 -> resp_valid=1 at cycle 2 with resp_data=32'h00000413 and resp_err=0. With resp_ready=1, req_ready=1 again at cycle 3.
2. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid, resp_data and resp_err stay constant and req_ready=0. Raise resp_ready -> handshake, then IDLE next cycle.
3. Faults:
   - Request 0x8000_0002 -> resp_err=1, resp_data=0.
   - Request 0x8000_4000 (beyond the 4096-word array) -> resp_err=1.
   - Request 0x7FFF_FFFC (wrapped offset) -> resp_err=1.
4. Flush: accept a request, assert flush 1 cycle later -> resp_valid never rises. A flush-cycle req_valid is not accepted. The next request gets the correct response at LATENCY.
5. Read-during-write: load_en writes mem[1]=0xDEADBEEF on the same edge that accepts a request to 0x8000_0004 (old value 0x11111111) -> resp_data=0x11111111. A subsequent fetch returns 0xDEADBEEF.
6. LATENCY=1 instance: accept at cycle 0 -> resp_valid at cycle 1. Asserting rst in WAIT/RESP -> resp_valid=0 next cycle and req_ready=1 after rst deasserts.
